rms_window_accumulator: RTL and testbench

RMS_WINDOW_ACCUMULATOR -- requirements
Module: rms_window_accumulator

---
 rtl/rms_window_accumulator.sv | 245 ++++++++++++++++++++++++
 tb/tb_rms_window_accumulator.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rms_window_accumulator.sv
// ---------------------------------------------------------------------------
// rms_window_accumulator
//
// Accumulates per-channel sums of squares of four signed ADC streams over a
// gated window (adcUseThisSample high). When the window closes, the sums,
// sample count and status flags are latched onto the outputs together with
// a one-cycle adcSumsValid pulse. A window that would overflow the sample
// counter is closed early and flagged as truncated. The rest of that gate
// window is then skipped.
//
// Ports
//   adcClk               sole clock, rising edge
//   adcReset             synchronous, active-high reset
//   adcValidIn           sample strobe for adc0In..adc3In
//   adc0In..adc3In       ADC words; the signed value sits in the top
//                        ADC_WIDTH bits and the padding LSBs are ignored
//   adcUseThisSample     window gate, aligned with adcValidIn
//   adcExceedsThreshold  trigger flag, aligned with adcValidIn
//   adcSum0..adcSum3     latched sum of squares of the last closed window
//   adcSumCount          number of samples in the last closed window
//   adcSumTriggered      trigger seen on at least one accumulated sample
//   adcSumTruncated      window closed because the counter hit its maximum
//   adcSumOverflow       at least one channel sum saturated
//   adcSumsValid         one-cycle pulse; new results on the outputs
// ---------------------------------------------------------------------------
module rms_window_accumulator #(
   parameter int ADC_WIDTH   = 16,
   parameter int DATA_WIDTH  = 16,
   parameter int SUM_WIDTH   = 48,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   adcClk,
   input  logic                   adcReset,
   input  logic                   adcValidIn,
   input  logic [DATA_WIDTH-1:0]  adc0In,
   input  logic [DATA_WIDTH-1:0]  adc1In,
   input  logic [DATA_WIDTH-1:0]  adc2In,
   input  logic [DATA_WIDTH-1:0]  adc3In,
   input  logic                   adcUseThisSample,
   input  logic                   adcExceedsThreshold,
   output logic [SUM_WIDTH-1:0]   adcSum0,
   output logic [SUM_WIDTH-1:0]   adcSum1,
   output logic [SUM_WIDTH-1:0]   adcSum2,
   output logic [SUM_WIDTH-1:0]   adcSum3,
   output logic [COUNT_WIDTH-1:0] adcSumCount,
   output logic                   adcSumTriggered,
   output logic                   adcSumTruncated,
   output logic                   adcSumOverflow,
   output logic                   adcSumsValid
);

   localparam int SQ_W = 2 * ADC_WIDTH;

   if (DATA_WIDTH < ADC_WIDTH) begin : g_bad_data_width
      $error("rms_window_accumulator: DATA_WIDTH must be >= ADC_WIDTH");
   end
   if (SUM_WIDTH < SQ_W) begin : g_bad_sum_width
      $error("rms_window_accumulator: SUM_WIDTH must be >= 2*ADC_WIDTH");
   end

   typedef enum logic [1:0] {IDLE, ACCUM, PUBLISH, WAIT_LOW} state_t;

   // Returns {saturated, sum}. The sum clamps to all-ones rather than wrapping.
   function automatic logic [SUM_WIDTH:0] sat_add(input logic [SUM_WIDTH-1:0] acc,
                                                  input logic [SQ_W-1:0]      sq);
      logic [SUM_WIDTH:0] total;
      total = {1'b0, acc} + (SUM_WIDTH+1)'(sq);
      if (total[SUM_WIDTH]) return {1'b1, {SUM_WIDTH{1'b1}}};
      return total;
   endfunction

   logic signed [ADC_WIDTH-1:0] ch_in [4];

   assign ch_in[0] = adc0In[DATA_WIDTH-1 -: ADC_WIDTH];
   assign ch_in[1] = adc1In[DATA_WIDTH-1 -: ADC_WIDTH];
   assign ch_in[2] = adc2In[DATA_WIDTH-1 -: ADC_WIDTH];
   assign ch_in[3] = adc3In[DATA_WIDTH-1 -: ADC_WIDTH];

   if (DATA_WIDTH > ADC_WIDTH) begin : g_pad
      logic pad_unused;
      assign pad_unused = ^{adc0In[DATA_WIDTH-ADC_WIDTH-1:0], adc1In[DATA_WIDTH-ADC_WIDTH-1:0],
                            adc2In[DATA_WIDTH-ADC_WIDTH-1:0], adc3In[DATA_WIDTH-ADC_WIDTH-1:0]};
   end

   // ---- stage 1: register operands and side-band flags ----
   logic signed [ADC_WIDTH-1:0] ch_p1 [4];
   logic                        vld_p1, use_p1, exc_p1;

   always_ff @(posedge adcClk) begin
      if (adcReset) vld_p1 <= 1'b0;
      else          vld_p1 <= adcValidIn;
   end

   always_ff @(posedge adcClk) begin
      use_p1 <= adcUseThisSample;
      exc_p1 <= adcExceedsThreshold;
      for (int i = 0; i < 4; i++) ch_p1[i] <= ch_in[i];
   end

   // ---- stage 2: register unsigned squares ----
   logic signed [SQ_W-1:0] prod [4];
   logic        [SQ_W-1:0] sq_p2 [4];
   logic                   vld_p2, use_p2, exc_p2;

   always_comb begin
      for (int i = 0; i < 4; i++) prod[i] = SQ_W'(ch_p1[i]) * SQ_W'(ch_p1[i]);
   end

   always_ff @(posedge adcClk) begin
      if (adcReset) vld_p2 <= 1'b0;
      else          vld_p2 <= vld_p1;
   end

   always_ff @(posedge adcClk) begin
      use_p2 <= use_p1;
      exc_p2 <= exc_p1;
      for (int i = 0; i < 4; i++) sq_p2[i] <= prod[i];
   end

   // ---- window FSM and accumulators (operate on stage-2 signals) ----
   state_t                 state, state_nxt;
   logic [SUM_WIDTH-1:0]   acc_sum [4];
   logic [SUM_WIDTH-1:0]   sum_nxt [4];
   logic [SUM_WIDTH:0]     add_res [4];
   logic [SUM_WIDTH:0]     start_res [4];
   logic [COUNT_WIDTH-1:0] acc_cnt, cnt_nxt, cnt_inc;
   logic                   acc_trig, trig_nxt;
   logic                   acc_trunc, trunc_nxt;
   logic                   acc_ovf, ovf_nxt;
   logic                   take, close, start_win, add_ovf, publish_load;

   assign take    = vld_p2 & use_p2;
   assign close   = vld_p2 & ~use_p2;
   assign cnt_inc = acc_cnt + COUNT_WIDTH'(1);

   always_comb begin
      add_ovf = 1'b0;
      for (int i = 0; i < 4; i++) begin
         add_res[i]   = sat_add(acc_sum[i], sq_p2[i]);
         start_res[i] = sat_add('0, sq_p2[i]);
         add_ovf      = add_ovf | add_res[i][SUM_WIDTH];
      end
   end

   always_comb begin
      state_nxt = state;
      for (int i = 0; i < 4; i++) sum_nxt[i] = acc_sum[i];
      cnt_nxt   = acc_cnt;
      trig_nxt  = acc_trig;
      trunc_nxt = acc_trunc;
      ovf_nxt   = acc_ovf;
      start_win = 1'b0;

      case (state)
         IDLE: begin
            if (take) start_win = 1'b1;
         end
         ACCUM: begin
            if (take) begin
               for (int i = 0; i < 4; i++) sum_nxt[i] = add_res[i][SUM_WIDTH-1:0];
               cnt_nxt  = cnt_inc;
               trig_nxt = acc_trig | exc_p2;
               ovf_nxt  = acc_ovf | add_ovf;
               if (cnt_inc == '1) begin
                  trunc_nxt = 1'b1;
                  state_nxt = PUBLISH;
               end
            end else if (close) begin
               state_nxt = PUBLISH;
            end
         end
         PUBLISH: begin
            // After a truncated window the gate is still open; skip the rest
            // of it instead of starting a fresh window mid-gate.
            if (acc_trunc)  state_nxt = WAIT_LOW;
            else if (take)  start_win = 1'b1;
            else            state_nxt = IDLE;
         end
         WAIT_LOW: begin
            if (close) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      if (start_win) begin
         for (int i = 0; i < 4; i++) sum_nxt[i] = start_res[i][SUM_WIDTH-1:0];
         cnt_nxt   = COUNT_WIDTH'(1);
         trig_nxt  = exc_p2;
         trunc_nxt = 1'b0;
         ovf_nxt   = 1'b0;
         state_nxt = ACCUM;
      end
   end

   // Results are latched on the edge entering PUBLISH so they are on the
   // outputs during the PUBLISH cycle, alongside adcSumsValid.
   assign publish_load = (state == ACCUM) && (state_nxt == PUBLISH);

   always_ff @(posedge adcClk) begin
      if (adcReset) begin
         state     <= IDLE;
         for (int i = 0; i < 4; i++) acc_sum[i] <= '0;
         acc_cnt   <= '0;
         acc_trig  <= 1'b0;
         acc_trunc <= 1'b0;
         acc_ovf   <= 1'b0;
      end else begin
         state     <= state_nxt;
         for (int i = 0; i < 4; i++) acc_sum[i] <= sum_nxt[i];
         acc_cnt   <= cnt_nxt;
         acc_trig  <= trig_nxt;
         acc_trunc <= trunc_nxt;
         acc_ovf   <= ovf_nxt;
      end
   end

   // ---- output registers ----
   logic [SUM_WIDTH-1:0] out_sum [4];

   always_ff @(posedge adcClk) begin
      if (adcReset) begin
         for (int i = 0; i < 4; i++) out_sum[i] <= '0;
         adcSumCount     <= '0;
         adcSumTriggered <= 1'b0;
         adcSumTruncated <= 1'b0;
         adcSumOverflow  <= 1'b0;
         adcSumsValid    <= 1'b0;
      end else begin
         adcSumsValid <= publish_load;
         if (publish_load) begin
            for (int i = 0; i < 4; i++) out_sum[i] <= sum_nxt[i];
            adcSumCount     <= cnt_nxt;
            adcSumTriggered <= trig_nxt;
            adcSumTruncated <= trunc_nxt;
            adcSumOverflow  <= ovf_nxt;
         end
      end
   end

   assign adcSum0 = out_sum[0];
   assign adcSum1 = out_sum[1];
   assign adcSum2 = out_sum[2];
   assign adcSum3 = out_sum[3];

endmodule

// File: tb/tb_rms_window_accumulator.sv
// ---------------------------------------------------------------------------
// tb_rms_window_accumulator
//
// Directed bench for rms_window_accumulator. Two instances share stimulus:
// u_dut uses default parameters; u_dut32 uses SUM_WIDTH=32 and 20-bit input
// words whose 4 padding LSBs carry a non-zero pattern that must be ignored.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_rms_window_accumulator;

   logic        clk = 1'b0;
   logic        rst;
   logic        vld, use_s, exc;
   logic [15:0] d0, d1, d2, d3;
   logic [19:0] e0, e1, e2, e3;

   logic [47:0] s0, s1, s2, s3;
   logic [7:0]  cnt;
   logic        trig, trunc, ovf, sv;

   logic [31:0] t0, t1, t2, t3;
   logic [7:0]  tcnt;
   logic        ttrig, ttrunc, tovf, tsv;

   int n_vec = 0;
   int n_err = 0;
   int pulses = 0;
   int pulse_snap;

   always #5 clk = ~clk;

   assign e0 = {d0, 4'hA};
   assign e1 = {d1, 4'h5};
   assign e2 = {d2, 4'hF};
   assign e3 = {d3, 4'h3};

   rms_window_accumulator u_dut (
      .adcClk(clk), .adcReset(rst), .adcValidIn(vld),
      .adc0In(d0), .adc1In(d1), .adc2In(d2), .adc3In(d3),
      .adcUseThisSample(use_s), .adcExceedsThreshold(exc),
      .adcSum0(s0), .adcSum1(s1), .adcSum2(s2), .adcSum3(s3),
      .adcSumCount(cnt), .adcSumTriggered(trig), .adcSumTruncated(trunc),
      .adcSumOverflow(ovf), .adcSumsValid(sv)
   );

   rms_window_accumulator #(.ADC_WIDTH(16), .DATA_WIDTH(20), .SUM_WIDTH(32), .COUNT_WIDTH(8)) u_dut32 (
      .adcClk(clk), .adcReset(rst), .adcValidIn(vld),
      .adc0In(e0), .adc1In(e1), .adc2In(e2), .adc3In(e3),
      .adcUseThisSample(use_s), .adcExceedsThreshold(exc),
      .adcSum0(t0), .adcSum1(t1), .adcSum2(t2), .adcSum3(t3),
      .adcSumCount(tcnt), .adcSumTriggered(ttrig), .adcSumTruncated(ttrunc),
      .adcSumOverflow(tovf), .adcSumsValid(tsv)
   );

   always @(posedge clk) begin
      if (sv) pulses <= pulses + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic step(input logic v, input logic u, input logic e,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] dd);
      vld = v; use_s = u; exc = e;
      d0 = a; d1 = b; d2 = c; d3 = dd;
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
   endtask

   // Presents the closing sample (exc high, which must not count), then
   // checks the pulse lands exactly three cycles after it.
   task automatic close_and_wait(input string tag);
      step(1'b1, 1'b0, 1'b1, 16'd9, 16'd9, 16'd9, 16'd9);
      idle();
      chk({tag, "_sv_early"}, 64'(sv), 64'd0);
      idle();
      chk({tag, "_sv_pulse"}, 64'(sv), 64'd1);
   endtask

   task automatic after_pulse(input string tag, input logic [7:0] exp_cnt);
      idle();
      chk({tag, "_sv_drop"}, 64'(sv), 64'd0);
      chk({tag, "_cnt_hold"}, 64'(cnt), 64'(exp_cnt));
   endtask

   initial begin
      rst = 1'b1;
      idle();
      idle();
      chk("rst_sv",    64'(sv),    64'd0);
      chk("rst_sum0",  64'(s0),    64'd0);
      chk("rst_cnt",   64'(cnt),   64'd0);
      chk("rst_flags", 64'({trig, trunc, ovf}), 64'd0);
      rst = 1'b0;
      idle();

      // Basic window: four samples per channel
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 16'd100, -16'sd100, 16'd0, 16'h8000);
      close_and_wait("basic");
      chk("basic_sum0",  64'(s0),  64'd40000);
      chk("basic_sum1",  64'(s1),  64'd40000);
      chk("basic_sum2",  64'(s2),  64'd0);
      chk("basic_sum3",  64'(s3),  64'd4294967296);
      chk("basic_cnt",   64'(cnt), 64'd4);
      chk("basic_flags", 64'({trig, trunc, ovf}), 64'd0);
      chk("basic32_sum0", 64'(t0), 64'd40000);
      chk("basic32_sum3", 64'(t3), 64'd4294967295);
      chk("basic32_ovf",  64'(tovf), 64'd1);
      after_pulse("basic", 8'd4);

      // Same window with invalid cycles interleaved (use/exc noise on them)
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b0, 16'd100, -16'sd100, 16'd0, 16'h8000);
         step(1'b0, 1'b0, 1'b1, 16'd7, 16'd7, 16'd7, 16'd7);
      end
      close_and_wait("gap");
      chk("gap_sum0",  64'(s0),  64'd40000);
      chk("gap_sum1",  64'(s1),  64'd40000);
      chk("gap_sum2",  64'(s2),  64'd0);
      chk("gap_sum3",  64'(s3),  64'd4294967296);
      chk("gap_cnt",   64'(cnt), 64'd4);
      chk("gap_flags", 64'({trig, trunc, ovf}), 64'd0);
      after_pulse("gap", 8'd4);

      // Trigger flag on one accumulated sample
      step(1'b1, 1'b1, 1'b0, 16'd3, -16'sd4, 16'd5, 16'd0);
      step(1'b1, 1'b1, 1'b1, 16'd3, -16'sd4, 16'd5, 16'd0);
      close_and_wait("trig");
      chk("trig_sum0", 64'(s0), 64'd18);
      chk("trig_sum1", 64'(s1), 64'd32);
      chk("trig_sum2", 64'(s2), 64'd50);
      chk("trig_cnt",  64'(cnt), 64'd2);
      chk("trig_flag", 64'(trig), 64'd1);
      after_pulse("trig", 8'd2);

      // Counter limit: 300 samples, window closes at 255
      pulse_snap = pulses;
      for (int i = 1; i <= 300; i++) begin
         step(1'b1, 1'b1, 1'b0, 16'd1000, 16'd0, 16'd0, 16'd0);
         if (i == 256) chk("trunc_sv_early", 64'(sv), 64'd0);
         if (i == 257) begin
            chk("trunc_sv_pulse", 64'(sv),    64'd1);
            chk("trunc_sum0",     64'(s0),    64'd255000000);
            chk("trunc_cnt",      64'(cnt),   64'd255);
            chk("trunc_flag",     64'(trunc), 64'd1);
         end
      end
      step(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
      idle();
      idle();
      idle();
      chk("trunc_pulse_count", 64'(pulses - pulse_snap), 64'd1);
      step(1'b1, 1'b1, 1'b0, 16'd1000, 16'd0, 16'd0, 16'd0);
      step(1'b1, 1'b1, 1'b0, 16'd1000, 16'd0, 16'd0, 16'd0);
      close_and_wait("rearm");
      chk("rearm_sum0",  64'(s0),    64'd2000000);
      chk("rearm_cnt",   64'(cnt),   64'd2);
      chk("rearm_trunc", 64'(trunc), 64'd0);
      after_pulse("rearm", 8'd2);

      // Saturation on the 32-bit instance; 48-bit instance must not saturate
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 16'h8000, 16'd0, 16'd0, 16'd0);
      close_and_wait("sat");
      chk("sat32_sv",   64'(tsv),  64'd1);
      chk("sat32_sum0", 64'(t0),   64'd4294967295);
      chk("sat32_ovf",  64'(tovf), 64'd1);
      chk("sat32_cnt",  64'(tcnt), 64'd5);
      chk("sat48_sum0", 64'(s0),   64'd5368709120);
      chk("sat48_ovf",  64'(ovf),  64'd0);
      after_pulse("sat", 8'd5);

      // Reset mid-window discards the partial window
      pulse_snap = pulses;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 16'd5, 16'd0, 16'd0, 16'd0);
      rst = 1'b1;
      step(1'b1, 1'b1, 1'b0, 16'd5, 16'd0, 16'd0, 16'd0);
      rst = 1'b0;
      chk("rstmid_sv",   64'(sv),  64'd0);
      chk("rstmid_sum0", 64'(s0),  64'd0);
      chk("rstmid_cnt",  64'(cnt), 64'd0);
      idle();
      step(1'b1, 1'b1, 1'b0, 16'd7, 16'd0, 16'd0, 16'd0);
      step(1'b1, 1'b1, 1'b0, 16'd7, 16'd0, 16'd0, 16'd0);
      close_and_wait("rstmid");
      chk("rstmid_sum0b", 64'(s0),  64'd98);
      chk("rstmid_cntb",  64'(cnt), 64'd2);
      after_pulse("rstmid", 8'd2);
      chk("rstmid_pulse_count", 64'(pulses - pulse_snap), 64'd1);

      // Back-to-back windows: B's first sample arrives in A's publish cycle
      step(1'b1, 1'b1, 1'b1, 16'd2, 16'd0, 16'd0, 16'd0);
      step(1'b1, 1'b1, 1'b1, 16'd2, 16'd0, 16'd0, 16'd0);
      step(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
      step(1'b1, 1'b1, 1'b0, 16'd3, 16'd0, 16'd0, 16'd0);
      step(1'b1, 1'b1, 1'b0, 16'd3, 16'd0, 16'd0, 16'd0);
      chk("b2b_a_sv",   64'(sv),   64'd1);
      chk("b2b_a_sum0", 64'(s0),   64'd8);
      chk("b2b_a_cnt",  64'(cnt),  64'd2);
      chk("b2b_a_trig", 64'(trig), 64'd1);
      step(1'b1, 1'b1, 1'b0, 16'd3, 16'd0, 16'd0, 16'd0);
      chk("b2b_a_drop", 64'(sv), 64'd0);
      close_and_wait("b2b_b");
      chk("b2b_b_sum0", 64'(s0),   64'd27);
      chk("b2b_b_cnt",  64'(cnt),  64'd3);
      chk("b2b_b_trig", 64'(trig), 64'd0);
      after_pulse("b2b_b", 8'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
